// File: rtl/id_exe_skid_reg_if.sv
// ============================================================================
// Module   : id_exe_skid_reg_if
// Brief    : ID->EXE bundle handshake interface (upstream + downstream sides)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface id_exe_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4,
    parameter int REG_AW = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] dest_in;
    logic [DATA_W-1:0] reg2_in;
    logic [DATA_W-1:0] val1_in;
    logic [DATA_W-1:0] val2_in;
    logic [DATA_W-1:0] pc_in;
    logic              br_taken_in;
    logic [CMD_W-1:0]  exe_cmd_in;
    logic              mem_r_en_in;
    logic              mem_w_en_in;
    logic              wb_en_in;

    logic              out_valid;
    logic              out_ready;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] pc_out;
    logic              br_taken;
    logic [CMD_W-1:0]  exe_cmd;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
    logic [1:0]        occupancy;

    // Driver side: ID producer, EXE consumer and flush source
    modport master (
        output flush, in_valid, dest_in, reg2_in, val1_in, val2_in, pc_in,
               br_taken_in, exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in,
               out_ready,
        input  in_ready, out_valid, dest, reg2, val1, val2, pc_out, br_taken,
               exe_cmd, mem_r_en, mem_w_en, wb_en, occupancy
    );

    // Pipeline register side
    modport slave (
        input  flush, in_valid, dest_in, reg2_in, val1_in, val2_in, pc_in,
               br_taken_in, exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in,
               out_ready,
        output in_ready, out_valid, dest, reg2, val1, val2, pc_out, br_taken,
               exe_cmd, mem_r_en, mem_w_en, wb_en, occupancy
    );
endinterface

`default_nettype wire

// File: rtl/id_exe_skid_reg.sv
// ============================================================================
// Module   : id_exe_skid_reg
// Brief    : Elastic ID->EXE register, 2-entry skid, registered upstream ready
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_exe_skid_reg #(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4,
    parameter int REG_AW = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    id_exe_skid_reg_if.slave bus
);
    localparam int c_BW = REG_AW + 4 * DATA_W + CMD_W + 4;

    logic [c_BW-1:0] head_q, head_d;
    logic [c_BW-1:0] skid_q, skid_d;
    logic            head_valid_q, head_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_ready_q, in_ready_d;
    logic [1:0]      occ_q, occ_d;

    logic [c_BW-1:0] w_in_bundle;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_br, w_mr, w_mw, w_wb;

    assign w_in_bundle = {bus.dest_in, bus.reg2_in, bus.val1_in, bus.val2_in,
                          bus.pc_in, bus.br_taken_in, bus.exe_cmd_in,
                          bus.mem_r_en_in, bus.mem_w_en_in, bus.wb_en_in};

    assign w_in_fire  = bus.in_valid & in_ready_q;
    assign w_out_fire = head_valid_q & bus.out_ready;

    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;

        if (bus.flush) begin
            // Kill everything; the flush-cycle input is dropped
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!head_valid_q) begin
            if (w_in_fire) begin
                head_d       = w_in_bundle;
                head_valid_d = 1'b1;
            end
        end else if (!skid_valid_q) begin
            if (w_in_fire && w_out_fire) begin
                head_d = w_in_bundle;
            end else if (w_in_fire) begin
                skid_d       = w_in_bundle;
                skid_valid_d = 1'b1;
            end else if (w_out_fire) begin
                head_valid_d = 1'b0;
            end
        end else if (w_out_fire) begin
            // Full: in_ready is low, so only a drain can happen
            head_d       = skid_q;
            skid_valid_d = 1'b0;
        end

        in_ready_d = ~skid_valid_d;
        occ_d      = {1'b0, head_valid_d} + {1'b0, skid_valid_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            occ_q        <= 2'd0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            occ_q        <= occ_d;
        end
    end

    assign {bus.dest, bus.reg2, bus.val1, bus.val2, bus.pc_out, w_br,
            bus.exe_cmd, w_mr, w_mw, w_wb} = head_q;

    // Side-effect flags must never leak from a bubble into EXE
    assign bus.br_taken  = w_br & head_valid_q;
    assign bus.mem_r_en  = w_mr & head_valid_q;
    assign bus.mem_w_en  = w_mw & head_valid_q;
    assign bus.wb_en     = w_wb & head_valid_q;

    assign bus.out_valid = head_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.occupancy = occ_q;
endmodule

`default_nettype wire
